// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   - selop encodings (OP_ADD .. OP_REMU)
//   - FSM state encoding
//   - is_multicycle(): selops that run on the iterative mul/div engine
// Optional feature macro used by the importers: ALU_SEQ_MULDIV_EN.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLTU = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] selop);
    return (selop == OP_MUL) || (selop == OP_DIVU) || (selop == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative shift-add multiplier / restoring divider.
// One bit per cycle, WIDTH cycles per operation. Only compiled into
// alu_seq when ALU_SEQ_MULDIV_EN is defined.
// Ports:
//   clk, rst        clock, async active-high reset (clears busy only)
//   start           pulse: latch a, b and the mode, begin iterating
//   mul, rem        mode at start: mul=1 multiply; else divu (rem=0) / remu (rem=1)
//   a, b            operands (multiplicand/dividend a, multiplier/divisor b)
//   done            high during the cycle whose edge retires the final iteration
//   result          value after the final iteration (valid while done=1)
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mul,
  input  logic             rem,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic          busy;
  logic [CW-1:0] cnt;
  logic          mul_q, rem_q;

  // acc: product accumulator / partial remainder
  // xr : shifting multiplicand / divisor
  // yr : shifting multiplier / quotient (dividend shifts out as quotient shifts in)
  logic [WIDTH-1:0] acc, xr, yr;
  logic [WIDTH-1:0] acc_nxt, x_nxt, y_nxt;
  logic [WIDTH:0]   r_sh, r_diff;
  logic             ge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mul_q <= mul;
      rem_q <= rem;
      acc   <= '0;
      xr    <= b;
      yr    <= a;
    end else if (busy) begin
      acc <= acc_nxt;
      xr  <= x_nxt;
      yr  <= y_nxt;
    end
  end

  always_comb begin
    r_sh   = {acc, yr[WIDTH-1]};
    r_diff = r_sh - {1'b0, xr};
    // remainder stays below the divisor, so bit WIDTH is a clean borrow
    ge     = ~r_diff[WIDTH];
    if (mul_q) begin
      acc_nxt = acc + (yr[0] ? xr : '0);
      x_nxt   = xr << 1;
      y_nxt   = yr >> 1;
    end else begin
      acc_nxt = ge ? r_diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
      x_nxt   = xr;
      y_nxt   = {yr[WIDTH-2:0], ge};
    end
  end

  assign done   = busy && (cnt == CW'(WIDTH - 1));
  assign result = (mul_q || rem_q) ? acc_nxt : y_nxt;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes on both sides.
// One op is accepted in IDLE; single-cycle ops register result/flags at
// the accept edge (out_valid the following cycle). Multi-cycle ops
// (mul/divu/remu) run WIDTH cycles in ITER. DONE holds result/flags until
// out_ready; no new op is accepted while in DONE.
// Optional macro ALU_SEQ_MULDIV_EN: enables mul/divu/remu via
// alu_seq_muldiv; without it those selops are illegal.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid, in_ready       input handshake (op_a, op_b, selop)
//   out_valid, out_ready     output handshake (result, flags)
//   result                   registered result
//   flag_c/z/n/v/error       carry/no-borrow, zero, negative, signed
//                            overflow, illegal selop or divide by zero
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       selop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_error
);

  localparam int SHW = $clog2(WIDTH);

  state_t state, state_nxt;

  logic                    accept, go_iter, md_done;
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_c, alu_v, alu_err;
  logic [WIDTH:0]          sum, dif;
  logic signed [WIDTH-1:0] a_s, b_s, sra_s;
  logic [SHW-1:0]          shamt;

  assign accept = in_valid && in_ready;
  assign a_s    = op_a;
  assign b_s    = op_b;
  assign shamt  = op_b[SHW-1:0];
  assign sra_s  = a_s >>> shamt;

`ifdef ALU_SEQ_MULDIV_EN
  logic [WIDTH-1:0] md_res;

  // divide by zero is resolved in the single-cycle path
  assign go_iter = is_multicycle(selop) && ((selop == OP_MUL) || (op_b != '0));

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && go_iter),
    .mul    (selop == OP_MUL),
    .rem    (selop == OP_REMU),
    .a      (op_a),
    .b      (op_b),
    .done   (md_done),
    .result (md_res)
  );
`else
  assign go_iter = 1'b0;
  assign md_done = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    sum     = {1'b0, op_a} + {1'b0, op_b};
    dif     = {1'b0, op_a} - {1'b0, op_b};
    case (selop)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif[WIDTH-1:0];
        alu_c   = ~dif[WIDTH];
        alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (dif[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = sra_s;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, dif[WIDTH]};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
`ifdef ALU_SEQ_MULDIV_EN
      // only reached here for mul's unused slot or a zero divisor
      OP_MUL:  alu_res = '0;
      OP_DIVU: begin
        alu_res = '1;
        alu_err = 1'b1;
      end
      OP_REMU: begin
        alu_res = op_a;
        alu_err = 1'b1;
      end
`endif
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = go_iter ? ST_ITER : ST_DONE;
      end
      ST_ITER: begin
        if (md_done) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      result     <= '0;
      flag_c     <= 1'b0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_v     <= 1'b0;
      flag_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        flag_c     <= go_iter ? 1'b0 : alu_c;
        flag_v     <= go_iter ? 1'b0 : alu_v;
        flag_error <= go_iter ? 1'b0 : alu_err;
        if (!go_iter) begin
          result <= alu_res;
          flag_z <= (alu_res == '0);
          flag_n <= alu_res[WIDTH-1];
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      if (md_done) begin
        result <= md_res;
        flag_z <= (md_res == '0);
        flag_n <= md_res[WIDTH-1];
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=32 main instance, WIDTH=8 second
// instance). Mul/div scenarios are compiled when ALU_SEQ_MULDIV_EN is set;
// otherwise the illegal-opcode behaviour of 1001/1010 is exercised.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [31:0] op_a, op_b;
  logic [3:0]  selop;
  logic        in_ready, out_valid;
  logic [31:0] result;
  logic        flag_c, flag_z, flag_n, flag_v, flag_error;

  logic        in_valid8, out_ready8;
  logic [7:0]  op_a8, op_b8;
  logic [3:0]  selop8;
  logic        in_ready8, out_valid8;
  logic [7:0]  result8;
  logic        flag_c8, flag_z8, flag_n8, flag_v8, flag_error8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .selop(selop), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_c(flag_c), .flag_z(flag_z),
    .flag_n(flag_n), .flag_v(flag_v), .flag_error(flag_error)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .op_a(op_a8), .op_b(op_b8), .selop(selop8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .flag_c(flag_c8), .flag_z(flag_z8),
    .flag_n(flag_n8), .flag_v(flag_v8), .flag_error(flag_error8)
  );

  // flag vector order: {c, z, n, v, error}
  function automatic logic [4:0] flags32();
    return {flag_c, flag_z, flag_n, flag_v, flag_error};
  endfunction

  // Issue one op on the 32-bit DUT; lat = cycles from accept to out_valid
  // (1 means out_valid in the cycle right after the accept cycle).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] s, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    op_a = a; op_b = b; selop = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; selop = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; op_a8 = '0; op_b8 = '0; selop8 = '0;
    #2;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++; $display("FAIL reset_handshake: got %b want 10", {in_ready, out_valid});
    end
    n_cmp++;
    if (result !== 32'h0 || flags32() !== 5'b0) begin
      n_bad++; $display("FAIL reset_outputs: got result %h flags %b want 0/00000", result, flags32());
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, lat);
    n_cmp++;
    if (lat !== 1) begin n_bad++; $display("FAIL add_latency: got %0d want 1", lat); end
    n_cmp++;
    if (result !== 32'h0) begin n_bad++; $display("FAIL add_result: got %h want 00000000", result); end
    n_cmp++;
    if (flags32() !== 5'b11000) begin n_bad++; $display("FAIL add_flags: got %b want 11000", flags32()); end
    release_out();
  endtask

  task automatic test_sub();
    int lat;
    run_op(32'h8000_0000, 32'h0000_0001, 4'b1000, lat);
    n_cmp++;
    if (result !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL sub_result: got %h want 7fffffff", result); end
    n_cmp++;
    if (flags32() !== 5'b10010) begin n_bad++; $display("FAIL sub_flags: got %b want 10010", flags32()); end
    release_out();
    // borrow case: 1 - 2 -> no-borrow flag clear, negative
    run_op(32'h1, 32'h2, 4'b1000, lat);
    n_cmp++;
    if (result !== 32'hFFFF_FFFF || flags32() !== 5'b00100) begin
      n_bad++; $display("FAIL sub_borrow: got %h/%b want ffffffff/00100", result, flags32());
    end
    release_out();
  endtask

  task automatic test_logic_shift_compare();
    logic [31:0] ta [10];
    logic [31:0] tb_ [10];
    logic [3:0]  ts [10];
    logic [31:0] te [10];
    logic [4:0]  fe;
    int lat;
    ta[0] = 32'hFFFF_FFFF; tb_[0] = 32'h1;          ts[0] = 4'b0011; te[0] = 32'h1;
    ta[1] = 32'hFFFF_FFFF; tb_[1] = 32'h1;          ts[1] = 4'b0010; te[1] = 32'h0;
    ta[2] = 32'h8000_0000; tb_[2] = 32'h24;         ts[2] = 4'b1101; te[2] = 32'hF800_0000;
    ta[3] = 32'hF0F0_F0F0; tb_[3] = 32'hFF00_FF00;  ts[3] = 4'b0111; te[3] = 32'hF000_F000;
    ta[4] = 32'hF0F0_F0F0; tb_[4] = 32'hFF00_FF00;  ts[4] = 4'b0110; te[4] = 32'hFFF0_FFF0;
    ta[5] = 32'hF0F0_F0F0; tb_[5] = 32'hFF00_FF00;  ts[5] = 4'b0100; te[5] = 32'h0FF0_0FF0;
    ta[6] = 32'h1;         tb_[6] = 32'h1F;         ts[6] = 4'b0001; te[6] = 32'h8000_0000;
    ta[7] = 32'h8000_0000; tb_[7] = 32'h21;         ts[7] = 4'b0101; te[7] = 32'h4000_0000;
    ta[8] = 32'h1;         tb_[8] = 32'hFFFF_FFFF;  ts[8] = 4'b0011; te[8] = 32'h0;
    ta[9] = 32'h1;         tb_[9] = 32'hFFFF_FFFF;  ts[9] = 4'b0010; te[9] = 32'h1;
    for (int i = 0; i < 10; i++) begin
      run_op(ta[i], tb_[i], ts[i], lat);
      fe = {1'b0, (te[i] == 32'h0), te[i][31], 1'b0, 1'b0};
      n_cmp++;
      if (result !== te[i] || flags32() !== fe || lat !== 1) begin
        n_bad++;
        $display("FAIL op_vec%0d sel=%b: got %h/%b lat %0d want %h/%b lat 1",
                 i, ts[i], result, flags32(), lat, te[i], fe);
      end
      release_out();
    end
  endtask

  task automatic test_hold_and_error();
    int lat;
    run_op(32'd5, 32'd3, 4'b0000, lat);
    // a competing op is presented while the result is held
    op_a = 32'd9; op_b = 32'd9; selop = 4'b0000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b10 || result !== 32'd8 || flags32() !== 5'b00000) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: got v/r %b result %h flags %b want 10/00000008/00000",
                 i, {out_valid, in_ready}, result, flags32());
      end
    end
    selop = 4'b1111;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL hold_release: got v/r %b want 01", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || result !== 32'h0 || flags32() !== 5'b01001) begin
      n_bad++;
      $display("FAIL illegal_op: got v %b result %h flags %b want 1/00000000/01001",
               out_valid, result, flags32());
    end
    release_out();
    run_op(32'd1, 32'd1, 4'b0000, lat);
    n_cmp++;
    if (result !== 32'd2 || flag_error !== 1'b0) begin
      n_bad++; $display("FAIL error_clear: got %h err %b want 00000002 err 0", result, flag_error);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    op_a = 32'd10; op_b = 32'd20; selop = 4'b0000;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (seen !== 4) begin n_bad++; $display("FAIL back_to_back_results: got %0d want 4", seen); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

`ifdef ALU_SEQ_MULDIV_EN
  task automatic test_muldiv();
    int lat;
    int seen;
    run_op(32'd7, 32'd6, 4'b1001, lat);
    n_cmp++;
    if (result !== 32'd42 || lat !== 33 || flags32() !== 5'b00000) begin
      n_bad++; $display("FAIL mul: got %0d lat %0d flags %b want 42 lat 33 flags 00000", result, lat, flags32());
    end
    release_out();
    run_op(32'd100, 32'd7, 4'b1010, lat);
    n_cmp++;
    if (result !== 32'd14 || lat !== 33) begin
      n_bad++; $display("FAIL divu: got %0d lat %0d want 14 lat 33", result, lat);
    end
    release_out();
    run_op(32'd100, 32'd7, 4'b1011, lat);
    n_cmp++;
    if (result !== 32'd2 || lat !== 33) begin
      n_bad++; $display("FAIL remu: got %0d lat %0d want 2 lat 33", result, lat);
    end
    release_out();
    run_op(32'h1234_5678, 32'h0, 4'b1010, lat);
    n_cmp++;
    if (result !== 32'hFFFF_FFFF || lat !== 1 || flags32() !== 5'b00101) begin
      n_bad++; $display("FAIL divu_zero: got %h lat %0d flags %b want ffffffff lat 1 flags 00101", result, lat, flags32());
    end
    release_out();
    run_op(32'd5, 32'h0, 4'b1011, lat);
    n_cmp++;
    if (result !== 32'd5 || lat !== 1 || flag_error !== 1'b1) begin
      n_bad++; $display("FAIL remu_zero: got %h lat %0d err %b want 00000005 lat 1 err 1", result, lat, flag_error);
    end
    release_out();
    // reset during ITER
    op_a = 32'd7; op_b = 32'd6; selop = 4'b1001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL iter_busy: got in_ready %b want 0", in_ready); end
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL iter_reset: got out_valid cycles %0d in_ready %b want 0/1", seen, in_ready);
    end
    run_op(32'd3, 32'd5, 4'b1001, lat);
    n_cmp++;
    if (result !== 32'd15) begin n_bad++; $display("FAIL mul_after_reset: got %0d want 15", result); end
    release_out();
  endtask
`else
  task automatic test_muldiv_disabled();
    int lat;
    run_op(32'd7, 32'd6, 4'b1001, lat);
    n_cmp++;
    if (result !== 32'h0 || lat !== 1 || flags32() !== 5'b01001) begin
      n_bad++; $display("FAIL mul_illegal: got %h lat %0d flags %b want 00000000 lat 1 flags 01001", result, lat, flags32());
    end
    release_out();
    run_op(32'd100, 32'd7, 4'b1010, lat);
    n_cmp++;
    if (result !== 32'h0 || lat !== 1 || flag_error !== 1'b1) begin
      n_bad++; $display("FAIL divu_illegal: got %h lat %0d err %b want 00000000 lat 1 err 1", result, lat, flag_error);
    end
    release_out();
  endtask
`endif

  task automatic test_width8();
    op_a8 = 8'hFF; op_b8 = 8'h01; selop8 = 4'b0000; in_valid8 = 1'b1;
    n_cmp++;
    if (in_ready8 !== 1'b1) begin n_bad++; $display("FAIL w8_ready: got %b want 1", in_ready8); end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n_cmp++;
    if (out_valid8 !== 1'b1 || result8 !== 8'h00 ||
        {flag_c8, flag_z8, flag_n8, flag_v8, flag_error8} !== 5'b11000) begin
      n_bad++;
      $display("FAIL w8_add: got v %b result %h flags %b want 1/00/11000", out_valid8, result8,
               {flag_c8, flag_z8, flag_n8, flag_v8, flag_error8});
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    n_cmp++;
    if (out_valid8 !== 1'b0) begin n_bad++; $display("FAIL w8_handshake: got %b want 0", out_valid8); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic_shift_compare();
    test_hold_and_error();
    test_back_to_back();
`ifdef ALU_SEQ_MULDIV_EN
    test_muldiv();
`else
    test_muldiv_disabled();
`endif
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, sequential successor to the core combinational ALU. Accepts one operation per valid/ready handshake and registers its result and flags. Adds signed compare, an overflow flag and a clean error flag. Optionally adds iterative multiply/divide. Sits between the decode/operand-fetch stage and writeback, so a multi-cycle op can stall the pipe through ready.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, power of two)
SHW, $clog2(WIDTH), shift-amount width (localparam, derived, not overridable)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands/selop valid
in_ready  out  1  block can accept an op
op_a  in  WIDTH  operand A
op_b  in  WIDTH  operand B
selop  in  4  operation select
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
flag_c  out  1  carry (add) / no-borrow (sub)
flag_z  out  1  result == 0
flag_n  out  1  result[WIDTH-1]
flag_v  out  1  signed overflow (add/sub only, else 0)
flag_error  out  1  illegal selop or divide by zero

Behaviour:
- Reset values:
  - in_ready=1; out_valid=0; result=0; all flags 0; FSM=IDLE.
  - Reset is async and acts at any time, including mid-ITER. The in-flight op is discarded and no out_valid is produced for it.
- FSM states IDLE, ITER, DONE:
  - IDLE: in_ready=1. On in_valid&&in_ready, operands and selop are latched.
    - Single-cycle op: go to DONE; out_valid=1 on the next edge (latency 1).
    - Mul/div op: go to ITER.
  - ITER: in_ready=0. Runs WIDTH iterations, one bit per cycle. Then goes to DONE (out_valid on cycle WIDTH+1 after accept).
  - DONE: out_valid=1. result and flags are held stable until out_ready=1. On out_valid&&out_ready: return to IDLE, out_valid=0.
    - in_ready=0 in DONE; no bypass.
    - Throughput for single-cycle ops: 1 op every 2 cycles.
- selop encodings (all others are illegal):
  - 0000 add; 1000 sub; 0111 and; 0110 or; 0100 xor.
  - 0001 sll; 0101 srl; 1101 sra. Shift amount = op_b[SHW-1:0]; upper bits ignored.
  - 0010 sltu; 0011 slt (signed). Both produce result 1 or 0.
  - 1001 mul (low WIDTH bits); 1010 divu; 1011 remu. These are legal only with ALU_SEQ_MULDIV_EN.
- Flags:
  - flag_c: add = carry out of bit WIDTH-1; sub = 1 when op_a>=op_b unsigned; 0 for all other ops.
  - flag_v: add = sign(a)==sign(b) && sign(r)!=sign(a); sub = sign(a)!=sign(b) && sign(r)!=sign(a).
  - flag_z and flag_n are computed from the final result for every op, including errors.
- Illegal selop: result=0, flag_error=1, flag_z=1, latency 1.
- flag_error is cleared on every new accepted op; it is never sticky.
- Divide by zero (op_b==0): no ITER, latency 1. divu result = all ones; remu result = op_a; flag_error=1.

Optional Feature:
ALU_SEQ_MULDIV_EN
- Defined: mul/divu/remu are implemented with an iterative shift-add multiplier and restoring divider, WIDTH cycles each.
- Undefined: the ITER datapath is not compiled. Opcodes 1001/1010/1011 are treated as illegal (result 0, flag_error=1, latency 1).

Decomposition:
- Package alu_seq_pkg holds:
  - the selop localparams (OP_ADD … OP_REMU);
  - the FSM state encoding;
  - the function is_multicycle(selop).
- One sub-module, alu_seq_muldiv (WIDTH-param, start/done pulse interface), containing the iterative engine. It is instantiated only under the macro.

Test Plan:
1. Add 0xFFFFFFFF+0x00000001 (WIDTH=32) -> out_valid 1 cycle after accept; result 0; flag_c=1, flag_z=1, flag_v=0.
2. Sub 0x80000000-0x00000001 -> result 0x7FFFFFFF; flag_v=1, flag_c=1, flag_n=0.
3. slt 0xFFFFFFFF,0x00000001 -> 1; sltu with the same operands -> 0. sra 0x80000000 by op_b=0x24 (amount 4) -> 0xF8000000.
4. Hold out_ready=0 for 5 cycles after a result -> result and flags stable, in_ready=0. Release -> next op is accepted the following cycle. selop 1111 -> result 0, flag_error=1.
5. With macro: mul 7*6 -> 42 after 33 cycles; divu 100/7 -> 14; remu -> 2; divu x/0 -> 0xFFFFFFFF with flag_error=1. Assert rst mid-ITER -> out_valid stays 0, in_ready=1 after release.
6. Without macro: selop 1001 -> error, latency 1. WIDTH=8 instance repeats scenario 1 with 0xFF+0x01.
